// File: rtl/euler_pkg.sv
// Shared state encoding and default widths for the Euler step sequencer.
package euler_pkg;

   localparam int EULER_DATA_SIZE  = 16;
   localparam int EULER_STEP_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LAUNCH   = 3'd1,
      WAIT_CLR = 3'd2,
      WAIT_FIN = 3'd3,
      DONE     = 3'd4
   } seq_state_e;

endpackage

// File: rtl/euler_step_watchdog.sv
// Per-step watchdog: down-counter loaded with the limit, terminal count flags a timeout.
// A zero limit loads zero and can never reach terminal count, which disables the watchdog.
module euler_step_watchdog #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 en,
   input  logic [TIMEOUT_W-1:0] limit,
   output logic                 limit_hit
);

   logic [TIMEOUT_W-1:0] remain_q;
   logic [TIMEOUT_W-1:0] remain_d;

   always_comb begin
      remain_d = remain_q;
      if (clear) begin
         remain_d = limit;
      end else if (en && (remain_q != '0)) begin
         remain_d = remain_q - TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remain_q <= '0;
      end else begin
         remain_q <= remain_d;
      end
   end

   // Fires during the limit-th enabled cycle after a load.
   assign limit_hit = en && (remain_q == TIMEOUT_W'(1));

endmodule

// File: rtl/euler_step_sequencer.sv
// Initiator side of the Euler core start/finish handshake: runs N back-to-back steps per command.
// Define EULER_SEQ_TIMEOUT_EN to add the timeout_limit/timeout_err ports and the per-step watchdog.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | cmd_ready high, waiting for a host command
//  LAUNCH   | core_start high for this single cycle
//  WAIT_CLR | waiting for the core to drop finish (stale high is ignored)
//  WAIT_FIN | waiting for finish to rise, then count the step
//  DONE     | done pulse, back to IDLE
module euler_step_sequencer
   import euler_pkg::*;
#(
   parameter int DATA_SIZE  = EULER_DATA_SIZE,
   parameter int STEP_CNT_W = EULER_STEP_CNT_W,
   parameter int TIMEOUT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_SIZE-1:0]  cmd_h_step,
   input  logic [STEP_CNT_W-1:0] cmd_n_steps,
`ifdef EULER_SEQ_TIMEOUT_EN
   input  logic [TIMEOUT_W-1:0]  timeout_limit,
   output logic                  timeout_err,
`endif
   output logic                  core_start,
   output logic [DATA_SIZE-1:0]  core_h_step,
   input  logic                  core_finish,
   output logic                  busy,
   output logic                  done,
   output logic [STEP_CNT_W-1:0] steps_done
);

   seq_state_e            state_q,      state_d;
   logic [DATA_SIZE-1:0]  h_step_q,     h_step_d;
   logic [STEP_CNT_W-1:0] n_steps_q,    n_steps_d;
   logic [STEP_CNT_W-1:0] steps_done_q, steps_done_d;
   logic                  core_start_q, core_start_d;
   logic                  done_q,       done_d;
   logic                  busy_q,       busy_d;
   logic                  cmd_ready_q,  cmd_ready_d;

   logic                  accept;
   logic                  wd_hit;
   logic                  timeout_fire;
   logic [STEP_CNT_W:0]   steps_inc;

   assign accept    = cmd_valid && cmd_ready_q;
   // One extra bit so the compare against N cannot be fooled by wrap.
   assign steps_inc = {1'b0, steps_done_q} + {{STEP_CNT_W{1'b0}}, 1'b1};

`ifdef EULER_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] limit_q, limit_d;
   logic                 timeout_err_q, timeout_err_d;

   euler_step_watchdog #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear     (state_q == LAUNCH),
      .en        ((state_q == WAIT_CLR) || (state_q == WAIT_FIN)),
      .limit     (limit_q),
      .limit_hit (wd_hit)
   );

   always_comb begin
      limit_d       = limit_q;
      timeout_err_d = timeout_err_q;
      if (accept) begin
         limit_d       = timeout_limit;
         timeout_err_d = 1'b0;
      end else if (timeout_fire) begin
         timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         limit_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         limit_q       <= limit_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      h_step_d     = h_step_q;
      n_steps_d    = n_steps_q;
      steps_done_d = steps_done_q;
      core_start_d = 1'b0;
      done_d       = 1'b0;
      timeout_fire = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               h_step_d     = cmd_h_step;
               n_steps_d    = cmd_n_steps;
               steps_done_d = '0;
               if (cmd_n_steps != '0) begin
                  state_d      = LAUNCH;
                  core_start_d = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         LAUNCH: begin
            state_d = WAIT_CLR;
         end
         WAIT_CLR: begin
            // A limit reached here means finish never cleared; that is a timeout too.
            if (wd_hit) begin
               timeout_fire = 1'b1;
               state_d      = DONE;
               done_d       = 1'b1;
            end else if (!core_finish) begin
               state_d = WAIT_FIN;
            end
         end
         WAIT_FIN: begin
            if (core_finish) begin
               steps_done_d = steps_inc[STEP_CNT_W-1:0];
               if (steps_inc < {1'b0, n_steps_q}) begin
                  state_d      = LAUNCH;
                  core_start_d = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else if (wd_hit) begin
               timeout_fire = 1'b1;
               state_d      = DONE;
               done_d       = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d      = (state_d != IDLE);
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         h_step_q     <= '0;
         n_steps_q    <= '0;
         steps_done_q <= '0;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         h_step_q     <= h_step_d;
         n_steps_q    <= n_steps_d;
         steps_done_q <= steps_done_d;
         core_start_q <= core_start_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign core_start  = core_start_q;
   assign core_h_step = h_step_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign steps_done  = steps_done_q;

endmodule

// File: doc/euler_step_sequencer.md
# euler_step_sequencer

Initiator side of the Euler core's start/finish handshake. Accepts a command (step size h, number of integration steps N) from the host, launches the Euler core N times back to back, counts completed steps and reports completion. It sits between the host command interface and the Euler top (`start`, `h_step`, `finish`), and replaces manual toggling of `start` by the testbench or host.

## Interface
**Parameters**
- `DATA_SIZE`, 16: width of h_step.
- `STEP_CNT_W`, 16: width of step count N and of `steps_done`.
- `TIMEOUT_W`, 16: width of the per-step watchdog limit.

**Ports**
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `cmd_valid`  in  1  host presents a command.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_h_step`  in  DATA_SIZE  step size, captured on accept.
- `cmd_n_steps`  in  STEP_CNT_W  number of steps N, captured on accept.
- `timeout_limit`  in  TIMEOUT_W  maximum cycles per step; sampled on accept. Present only with the macro.
- `core_start`  out  1  start pulse to the Euler core.
- `core_h_step`  out  DATA_SIZE  registered h to the core, stable for the whole command.
- `core_finish`  in  1  core finish level; stays high until the core sees `start` while `finish` is high.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle pulse when all N steps have finished.
- `steps_done`  out  STEP_CNT_W  count of completed steps in the current command.
- `timeout_err`  out  1  sticky watchdog error. Present only with the macro.

## Operation
- **Reset values:** state IDLE, `cmd_ready`=1, `core_start`=0, `core_h_step`=0, `busy`=0, `done`=0, `steps_done`=0, `timeout_err`=0.
- **Accept:** a command is accepted when `cmd_valid & cmd_ready`. On accept:
  - h and N are latched.
  - `steps_done` is cleared.
  - `timeout_err` is cleared.
- **States:**
  - **IDLE:** on accept, go to LAUNCH if N≠0. If N=0, go to DONE and do not pulse `core_start`.
  - **LAUNCH:** drive `core_start`=1 for exactly one cycle. If `core_finish` is still high from the previous command, this pulse both clears it and launches the new step. Then go to WAIT_CLR.
  - **WAIT_CLR:** wait until `core_finish`=0, then go to WAIT_FIN. A stale high `finish` is never counted as a completion.
  - **WAIT_FIN:** wait for `core_finish`=1. Then increment `steps_done`. If `steps_done`+1 < N, go to LAUNCH; otherwise go to DONE.
  - **DONE:** drive `done`=1 for one cycle, then go to IDLE.
- **After the last step:** the sequencer leaves `core_finish` high. The core stays idle and holds its result until the next command's start pulse.
- **Counter width:** `steps_done` is an unsigned counter of width STEP_CNT_W. It never wraps, because N ≤ 2^STEP_CNT_W−1 and counting stops at N.
- **`busy`:** 1 in LAUNCH, WAIT_CLR, WAIT_FIN and DONE.
- **`cmd_valid` while busy:** ignored. The command is not queued.
- **Reset mid-command:** immediately returns to the reset values. The core is not acknowledged; host firmware resets the core together with the sequencer.

## Timing
- Accept at edge k → `core_start` high during cycle k+1.
- `core_finish` seen high at edge j → next `core_start` in cycle j+1. Per-step overhead is 1 cycle plus the core's finish-clear latency.
- `done` is high in the cycle after the final finish is observed. `steps_done`=N in that same cycle.
- N=0: `done` is high in the cycle after accept. `core_start` stays 0.
- Finish rise and host `cmd_valid` in the same cycle: no interaction, because `cmd_ready`=0.

## Configuration
- **`EULER_SEQ_TIMEOUT_EN` defined:**
  - A watchdog counts cycles spent in WAIT_CLR plus WAIT_FIN for each step.
  - When the count reaches `timeout_limit`, the sequencer sets `timeout_err`, pulses `done`, and returns to IDLE with `steps_done` left at its partial value.
  - `timeout_limit`=0 disables the watchdog.
- **Undefined:** the `timeout_limit` and `timeout_err` ports and the watchdog logic are absent. The sequencer waits indefinitely for `core_finish`.

## Structure
- **Package `euler_pkg`:**
  - state enum (IDLE, LAUNCH, WAIT_CLR, WAIT_FIN, DONE);
  - default widths `EULER_DATA_SIZE`=16 and `EULER_STEP_CNT_W`=16.
- **Sub-module `euler_step_watchdog`:** a loadable counter with a `clear` input, an enable input and a `limit_hit` output. It is instantiated only under the macro.

## Test plan
- **Single step, clean core:** h=0x0100, N=1, core raises finish 20 cycles after start → exactly one `core_start` pulse, `done` 1 cycle after finish, `steps_done`=1, `core_h_step`=0x0100.
- **Multi-step:** N=5, core finishes 10 cycles after each start → 5 start pulses, each one cycle after the finish rise, `done` once, `steps_done`=5, and no extra start after the 5th finish.
- **Stale finish:** `core_finish` held high from the previous command, new N=2 → the first start clears it, nothing is counted until a new rising finish, final `steps_done`=2.
- **Zero steps:** N=0 → no `core_start`, `done` the cycle after accept, `busy` high for 1 cycle.
- **Reset mid-command:** `rst`=0 during WAIT_FIN of step 3 of 4 → all outputs return to reset values immediately, and `cmd_ready`=1 after `rst` rises.
- **Timeout (macro on):** `timeout_limit`=50, core never finishes → `timeout_err`=1 and `done` pulse after 50 wait cycles, `steps_done`=0; the next accept clears `timeout_err`.
